// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Opcodes, FSM state and engine mode types shared by the ALU files.
// Rev    : 1.0
// ============================================================================
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_if
// Brief  : Request/result bundle between the EX-stage control and alu_seq.
// Rev    : 1.0
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       select;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] resultHi;
  logic             Cout;
  logic             zero;
  logic             divByZero;

  modport master (
    output start, select, a, b,
    input  busy, done, aluResult, resultHi, Cout, zero, divByZero
  );

  modport slave (
    input  start, select, a, b,
    output busy, done, aluResult, resultHi, Cout, zero, divByZero
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module : alu_muldiv_iter
// Brief  : One-bit-per-cycle shift-add multiplier / restoring divider.
// Rev    : 1.0
// ============================================================================
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic             step,
  input  wire mode_t            mode,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] acc_hi,
  output logic      [WIDTH-1:0] acc_lo,
  output logic                  step_done
);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  mode_t            r_mode;

  logic [WIDTH-1:0] w_src_hi, w_src_lo, w_src_b;
  mode_t            w_src_mode;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;
  logic [WIDTH-1:0] w_nxt_hi, w_nxt_lo;
  logic             w_ge;

  // Load already performs the first step straight from the fresh operands,
  // so the final value is ready one cycle earlier than a load-then-step scheme.
  always_comb begin
    w_src_hi   = load ? '0   : r_hi;
    w_src_lo   = load ? a    : r_lo;
    w_src_b    = load ? b    : r_b;
    w_src_mode = load ? mode : r_mode;

    w_sum   = {1'b0, w_src_hi} + {1'b0, (w_src_lo[0] ? w_src_b : '0)};
    w_shift = {w_src_hi, w_src_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, w_src_b};
    // Partial remainder stays below b, so the top bit of the difference is the borrow.
    w_ge    = ~w_diff[WIDTH];

    if (w_src_mode == MODE_MUL) begin
      w_nxt_hi = w_sum[WIDTH:1];
      w_nxt_lo = {w_sum[0], w_src_lo[WIDTH-1:1]};
    end else begin
      w_nxt_hi = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_nxt_lo = {w_src_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_mode <= MODE_MUL;
    end else begin
      if (load) begin
        r_b    <= b;
        r_mode <= mode;
      end
      if (load || step) begin
        r_hi <= w_nxt_hi;
        r_lo <= w_nxt_lo;
      end
    end
  end

  assign acc_hi    = r_hi;
  assign acc_lo    = r_lo;
  assign step_done = load | step;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_seq
// Brief  : Registered ALU with start/done handshake and iterative mul/div/rem.
// Rev    : 1.0
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic clock,
  input  wire logic reset,
  alu_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_iter_last = CNT_W'(WIDTH - 2);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result, r_hi;
  logic             r_cout, r_zero, r_dbz, r_done;

  logic             w_load, w_step, w_step_done, w_upd;
  logic [WIDTH-1:0] w_res, w_hi, w_acc_hi, w_acc_lo, w_sc_res;
  logic             w_cout, w_dbz, w_sc_cout, w_iter_op, w_div_zero;
  logic [WIDTH:0]   w_add, w_sub;
  mode_t            w_mode;

  assign w_iter_op  = (bus.select == OP_MULU) || (bus.select == OP_DIVU) ||
                      (bus.select == OP_REMU);
  assign w_div_zero = ((bus.select == OP_DIVU) || (bus.select == OP_REMU)) &&
                      (bus.b == '0);
  assign w_mode     = (bus.select == OP_MULU) ? MODE_MUL : MODE_DIV;
  assign w_add      = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub      = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);

  // Divide-by-zero results share this path since they also finish in one cycle.
  always_comb begin
    w_sc_res  = '0;
    w_sc_cout = 1'b0;
    case (bus.select)
      OP_ADD:  begin w_sc_res = w_add[WIDTH-1:0]; w_sc_cout = w_add[WIDTH]; end
      OP_SUB:  begin w_sc_res = w_sub[WIDTH-1:0]; w_sc_cout = w_sub[WIDTH]; end
      OP_AND:  w_sc_res = bus.a & bus.b;
      OP_OR:   w_sc_res = bus.a | bus.b;
      OP_NAND: w_sc_res = ~(bus.a & bus.b);
      OP_NOR:  w_sc_res = ~(bus.a | bus.b);
      OP_XOR:  w_sc_res = bus.a ^ bus.b;
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_DIVU: w_sc_res = '1;
      OP_REMU: w_sc_res = bus.a;
      default: w_sc_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_engine (
    .clock     (clock),
    .reset     (reset),
    .load      (w_load),
    .step      (w_step),
    .mode      (w_mode),
    .a         (bus.a),
    .b         (bus.b),
    .acc_hi    (w_acc_hi),
    .acc_lo    (w_acc_lo),
    .step_done (w_step_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_upd       = 1'b0;
    w_res       = '0;
    w_hi        = '0;
    w_cout      = 1'b0;
    w_dbz       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_iter_op && !w_div_zero) begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ITER;
          end else begin
            w_upd  = 1'b1;
            w_res  = w_sc_res;
            w_cout = w_sc_cout;
            w_dbz  = w_div_zero;
          end
        end
      end
      ITER: begin
        w_step = 1'b1;
        if (w_step_done) begin
          if (r_cnt == c_iter_last) w_state_nxt = FINISH;
          else                      w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      FINISH: begin
        w_upd       = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
        case (r_op)
          OP_MULU: begin w_res = w_acc_lo; w_hi = w_acc_hi; end
          OP_DIVU: w_res = w_acc_lo;
          default: w_res = w_acc_hi;
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_op <= bus.select;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_hi     <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_upd;
      if (w_upd) begin
        r_result <= w_res;
        r_hi     <= w_hi;
        r_cout   <= w_cout;
        r_zero   <= (w_res == '0);
        r_dbz    <= w_dbz;
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.aluResult = r_result;
  assign bus.resultHi  = r_hi;
  assign bus.Cout      = r_cout;
  assign bus.zero      = r_zero;
  assign bus.divByZero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_seq
// Brief  : Drives 8/16/32-bit alu_seq instances in lockstep against a model.
// Rev    : 1.0
// ============================================================================
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        cout;
    logic        zero;
    logic        dbz;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  sel;
  logic [63:0] opa, opb;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();
  alu_seq_if #(.WIDTH(32)) if32 ();

  assign if8.start  = start;  assign if8.select  = sel;
  assign if16.start = start;  assign if16.select = sel;
  assign if32.start = start;  assign if32.select = sel;
  assign if8.a  = opa[7:0];   assign if8.b  = opb[7:0];
  assign if16.a = opa[15:0];  assign if16.b = opb[15:0];
  assign if32.a = opa[31:0];  assign if32.b = opb[31:0];

  alu_seq #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(if8));
  alu_seq #(.WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(if16));
  alu_seq #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(if32));

  logic [63:0] o_res [3];
  logic [63:0] o_hi  [3];
  logic        o_done[3], o_busy[3], o_cout[3], o_zero[3], o_dbz[3];

  assign o_res[0] = 64'(if8.aluResult);  assign o_hi[0] = 64'(if8.resultHi);
  assign o_res[1] = 64'(if16.aluResult); assign o_hi[1] = 64'(if16.resultHi);
  assign o_res[2] = 64'(if32.aluResult); assign o_hi[2] = 64'(if32.resultHi);
  assign o_done = '{if8.done, if16.done, if32.done};
  assign o_busy = '{if8.busy, if16.busy, if32.busy};
  assign o_cout = '{if8.Cout, if16.Cout, if32.Cout};
  assign o_zero = '{if8.zero, if16.zero, if32.zero};
  assign o_dbz  = '{if8.divByZero, if16.divByZero, if32.divByZero};

  function automatic int wd(input int i);
    return 8 << i;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on masked operands.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in);
    exp_t         e;
    logic [63:0]  m, a, b;
    logic [127:0] p;
    m = (64'd1 << w) - 64'd1;
    a = a_in & m;
    b = b_in & m;
    e.res = '0; e.hi = '0; e.cout = 1'b0; e.dbz = 1'b0;
    case (op)
      OP_ADD:  begin p = 128'(a) + 128'(b); e.res = p[63:0] & m; e.cout = p[w]; end
      OP_SUB:  begin e.res = (a - b) & m; e.cout = (a >= b); end
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_NAND: e.res = ~(a & b) & m;
      OP_NOR:  e.res = ~(a | b) & m;
      OP_XOR:  e.res = a ^ b;
      OP_SLTU: e.res = (a < b) ? 64'd1 : 64'd0;
      OP_MULU: begin
        p = 128'(a) * 128'(b);
        e.res = p[63:0] & m;
        e.hi  = 64'(p >> w) & m;
      end
      OP_DIVU: if (b == 0) begin e.res = m; e.dbz = 1'b1; end else e.res = a / b;
      OP_REMU: if (b == 0) begin e.res = a; e.dbz = 1'b1; end else e.res = a % b;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                       input bit poke);
    exp_t e[3];
    int   lat[3], seen[3], last;
    bit   all;
    for (int i = 0; i < 3; i++) begin
      e[i]    = model(wd(i), op, av, bv);
      lat[i]  = ((op == OP_MULU) ||
                 (((op == OP_DIVU) || (op == OP_REMU)) && ((bv & ((64'd1 << wd(i)) - 1)) != 0)))
                ? wd(i) + 1 : 1;
      seen[i] = 0;
    end
    @(negedge clock);
    sel = op; opa = av; opb = bv; start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) begin
        start = 1'b0;
        opa = ~opa;
        opb = {$urandom, $urandom};
        if (lat[1] > 1) check_val("busy16_after_start", 64'(o_busy[1]), 64'd1);
      end
      if (poke && n == 3) begin start = 1'b1; sel = OP_ADD; end
      if (poke && n == 4) start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (seen[i] == 0 && o_done[i]) begin
          seen[i] = n;
          check_val($sformatf("op%0d w%0d res", op, wd(i)),  o_res[i], e[i].res);
          check_val($sformatf("op%0d w%0d hi", op, wd(i)),   o_hi[i], e[i].hi);
          check_val($sformatf("op%0d w%0d cout", op, wd(i)), 64'(o_cout[i]), 64'(e[i].cout));
          check_val($sformatf("op%0d w%0d zero", op, wd(i)), 64'(o_zero[i]), 64'(e[i].zero));
          check_val($sformatf("op%0d w%0d dbz", op, wd(i)),  64'(o_dbz[i]), 64'(e[i].dbz));
          check_val($sformatf("op%0d w%0d busy_at_done", op, wd(i)), 64'(o_busy[i]), 64'd0);
        end else if (seen[i] != 0 && n == seen[i] + 1) begin
          check_val($sformatf("op%0d w%0d done_pulse", op, wd(i)), 64'(o_done[i]), 64'd0);
        end
      end
      all  = (seen[0] != 0) && (seen[1] != 0) && (seen[2] != 0);
      last = (seen[0] > seen[1]) ? seen[0] : seen[1];
      last = (seen[2] > last) ? seen[2] : last;
      if (all && n > last) break;
    end
    for (int i = 0; i < 3; i++)
      check_val($sformatf("op%0d w%0d latency", op, wd(i)), 64'(seen[i]), 64'(lat[i]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d", n_total);
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int          n, idx, dcnt;
    logic [63:0] ra, rb;
    logic [3:0]  rop;

    reset = 1'b1; start = 1'b0; sel = OP_ADD; opa = '0; opb = '0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst w%0d res", wd(i)), o_res[i], 64'd0);
      check_val($sformatf("rst w%0d flags", wd(i)),
                {59'd0, o_busy[i], o_done[i], o_cout[i], o_zero[i], o_dbz[i]}, 64'd0);
    end
    check_val("rst w16 hi", o_hi[1], 64'd0);
    reset = 1'b0;

    // Directed cases
    do_op(OP_ADD,  64'hFFFF_FFFF, 64'h1, 1'b0);
    do_op(OP_SUB,  64'd5, 64'd7, 1'b0);
    do_op(OP_SLTU, 64'd3, 64'd9, 1'b0);
    do_op(OP_SLTU, 64'd9, 64'd3, 1'b0);
    do_op(OP_AND,  64'hF0F0, 64'h0FF0, 1'b0);
    do_op(OP_OR,   64'hF0F0, 64'h0FF0, 1'b0);
    do_op(OP_NAND, 64'hF0F0, 64'h0FF0, 1'b0);
    do_op(OP_NOR,  64'hF0F0, 64'h0FF0, 1'b0);
    do_op(OP_XOR,  64'hF0F0, 64'h0FF0, 1'b0);
    do_op(4'd13,   64'h1234, 64'h5678, 1'b0);
    do_op(OP_MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
    do_op(OP_DIVU, 64'd1000, 64'd7, 1'b0);
    do_op(OP_REMU, 64'd1000, 64'd7, 1'b0);
    do_op(OP_DIVU, 64'd1000, 64'd0, 1'b0);
    do_op(OP_REMU, 64'd1000, 64'd0, 1'b0);

    // Reset in the middle of a multiply
    do_op(OP_XOR, 64'hA5A5_A5A5, 64'h0F0F_0F0F, 1'b0);
    @(negedge clock);
    sel = OP_MULU; opa = 64'h1234_5678; opb = 64'h9ABC_DEF1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("midrst w%0d res", wd(i)), o_res[i], 64'd0);
      check_val($sformatf("midrst w%0d hi", wd(i)), o_hi[i], 64'd0);
      check_val($sformatf("midrst w%0d flags", wd(i)),
                {59'd0, o_busy[i], o_done[i], o_cout[i], o_zero[i], o_dbz[i]}, 64'd0);
    end
    @(negedge clock); reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clock);
      dcnt += int'(o_done[0]) + int'(o_done[1]) + int'(o_done[2]);
    end
    check_val("no_done_after_reset", 64'(dcnt), 64'd0);
    do_op(OP_ADD, 64'd100, 64'd23, 1'b0);

    // Start held high, alternating mulu/add on the 16-bit instance
    @(negedge clock);
    sel = OP_MULU; opa = {$urandom, $urandom}; opb = {$urandom, $urandom}; start = 1'b1;
    n = 0; idx = 0;
    for (int g = 0; g < 200 && idx < 6; g++) begin
      @(negedge clock);
      n++;
      if (o_done[1]) begin
        e = model(16, sel, opa, opb);
        check_val($sformatf("b2b%0d latency", idx), 64'(n), (sel == OP_MULU) ? 64'd17 : 64'd1);
        check_val($sformatf("b2b%0d res", idx), o_res[1], e.res);
        check_val($sformatf("b2b%0d hi", idx), o_hi[1], e.hi);
        idx++; n = 0;
        sel = (sel == OP_MULU) ? OP_ADD : OP_MULU;
        opa = {$urandom, $urandom}; opb = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    check_val("b2b ops_completed", 64'(idx), 64'd6);
    repeat (40) @(negedge clock);

    // Random iterative operands
    for (int k = 0; k < 1000; k++) begin
      rop = 4'(OP_MULU + 4'($urandom_range(0, 2)));
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = rb & 64'hF;
      do_op(rop, ra, rb, 1'b0);
    end
    // Random ops across the whole opcode space
    for (int k = 0; k < 200; k++) begin
      rop = 4'($urandom_range(0, 15));
      do_op(rop, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
